// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester command/response bundle for ram_arbiter
//
// Purpose: one requester port of the RAM arbiter.
//   master modport: the requester (drives req/we/addr/wdata)
//   slave modport : the arbiter (drives ready/done/rdata)
// Signals:
//   req    command valid, held with its fields until ready
//   we     1 = write, 0 = read
//   addr   RAM address
//   wdata  write data
//   ready  command accepted this cycle (combinational)
//   done   command complete, one-cycle pulse (registered)
//   rdata  read data, valid while done is high for a read (registered)
interface ram_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, done, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, done, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter/sequencer for a 64x8 single-port RAM
//
// Purpose: serialises read/write commands from two requesters onto one
// single-port RAM whose read address is registered, and returns a done
// pulse per command plus registered read data for reads.
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   p0, p1        requester ports (ram_arbiter_if.slave)
//   ram_write_en  RAM write enable (only in ACCESS of a write, gated by rst)
//   ram_address   RAM address (latched command address)
//   ram_data_in   RAM write data (latched command data)
//   ram_data_out  RAM read data (valid the cycle after the address is captured)
// Configuration:
//   RAM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins a conflict;
//                          otherwise conflicts are resolved round-robin.
module ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      p0,
  ram_arbiter_if.slave      p1,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic winner;
  logic ready0;
  logic ready1;

  // Winner selection: a lone requester always wins; on conflict the port
  // that was not granted last time wins (or port 0 in fixed-priority mode).
  always_comb begin
    winner = 1'b0;
    if (p0.req && p1.req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant_q;
`endif
    end else if (p1.req) begin
      winner = 1'b1;
    end
  end

  assign ready0 = (state_q == IDLE) && p0.req && !winner;
  assign ready1 = (state_q == IDLE) && p1.req &&  winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (ready0 || ready1) begin
          port_d       = winner;
          we_d         = winner ? p1.we    : p0.we;
          addr_d       = winner ? p1.addr  : p0.addr;
          wdata_d      = winner ? p1.wdata : p0.wdata;
          last_grant_d = winner;
          state_d      = ACCESS;
        end
      end

      ACCESS: begin
        // A write lands in the RAM at the end of this cycle and is complete.
        // A read only loads the RAM's address register here; data follows.
        if (we_q) begin
          state_d = IDLE;
          if (port_q) begin
            done1_d = 1'b1;
          end else begin
            done0_d = 1'b1;
          end
        end else begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (port_q) begin
          rdata1_d = ram_data_out;
          done1_d  = 1'b1;
        end else begin
          rdata0_d = ram_data_out;
          done0_d  = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // rst gates the write strobe directly so a command caught mid-ACCESS by
  // reset never reaches the RAM.
  assign ram_write_en = (state_q == ACCESS) && we_q && !rst;
  assign ram_address  = addr_q;
  assign ram_data_in  = wdata_q;

  assign p0.ready = ready0;
  assign p1.ready = ready1;
  assign p0.done  = done0_q;
  assign p1.done  = done1_q;
  assign p0.rdata = rdata0_q;
  assign p1.rdata = rdata1_q;

endmodule
